// File: rtl/data_transfer.sv
// Banked FIFO: NUM_BANKS single-port banks striped round-robin by pointer,
// registered read data with a one-clock latency and one-cycle error pulses.
module data_transfer #(
    parameter int DATA_W     = 16,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 4,
    localparam int DEPTH  = NUM_BANKS * BANK_DEPTH,
    localparam int BANK_W = $clog2(NUM_BANKS),
    localparam int ROW_W  = $clog2(BANK_DEPTH),
    localparam int PTR_W  = BANK_W + ROW_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              wr_err,
    output logic              rd_err
);

    logic [DATA_W-1:0] mem_r [NUM_BANKS][BANK_DEPTH];

    logic [PTR_W-1:0]  wptr_r;
    logic [PTR_W-1:0]  rptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] out_r;
    logic              out_valid_r;
    logic              wr_err_r;
    logic              rd_err_r;

    logic              full_s;
    logic              empty_s;
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [BANK_W-1:0] wbank_s;
    logic [ROW_W-1:0]  wrow_s;
    logic [BANK_W-1:0] rbank_s;
    logic [ROW_W-1:0]  rrow_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Low pointer bits select the bank so consecutive words stripe across banks.
    assign wbank_s = wptr_r[BANK_W-1:0];
    assign wrow_s  = wptr_r[PTR_W-1:BANK_W];
    assign rbank_s = rptr_r[BANK_W-1:0];
    assign rrow_s  = rptr_r[PTR_W-1:BANK_W];

    // Accept decisions and next occupancy; a read frees the slot a full-time write needs.
    always_comb begin
        rd_ok_s     = 1'b0;
        wr_ok_s     = 1'b0;
        count_nxt_s = count_r;
        rd_ok_s     = rd & ~empty_s;
        wr_ok_s     = wr & (~full_s | rd_ok_s);
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Bank storage; contents survive reset, but reset blocks any write.
    always_ff @(posedge clk) begin
        if (rst && wr_ok_s) begin
            mem_r[wbank_s][wrow_s] <= a;
        end
    end

    // Pointers, occupancy, read data register and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_r      <= {PTR_W{1'b0}};
            rptr_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_r       <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            wr_err_r    <= 1'b0;
            rd_err_r    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (rd_ok_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
                out_r  <= mem_r[rbank_s][rrow_s];
            end
            count_r     <= count_nxt_s;
            out_valid_r <= rd_ok_s;
            wr_err_r    <= wr & ~wr_ok_s;
            rd_err_r    <= rd & ~rd_ok_s;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_r;
    assign wr_err    = wr_err_r;
    assign rd_err    = rd_err_r;

endmodule

// File: tb/tb_data_transfer.sv
// Bench for data_transfer: directed scenarios plus random traffic, every cycle
// compared against a queue-based FIFO model.
module tb_data_transfer;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic        wr;
    logic        rd;
    logic [15:0] out;
    logic        out_valid;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        wr_err;
    logic        rd_err;

    int num_tests = 0;
    int num_fail  = 0;
    int cyc       = 0;

    // Reference model state
    logic [15:0] m_q[$];
    logic [15:0] m_out;
    logic        m_ov;
    logic        m_we;
    logic        m_re;

    data_transfer dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .wr        (wr),
        .rd        (rd),
        .out       (out),
        .out_valid (out_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .wr_err    (wr_err),
        .rd_err    (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_tests++;
        if (obs !== exp) begin
            num_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare every output after the edge.
    task automatic step(input logic r, input logic w, input logic d, input logic [15:0] din);
        bit rd_acc;
        bit wr_acc;
        rst = r; wr = w; rd = d; a = din;
        if (!r) begin
            m_q.delete();
            m_out = 16'h0000;
            m_ov  = 1'b0;
            m_we  = 1'b0;
            m_re  = 1'b0;
        end else begin
            rd_acc = d && (m_q.size() > 0);
            wr_acc = w && ((m_q.size() < 16) || rd_acc);
            m_ov   = rd_acc;
            m_re   = d && !rd_acc;
            m_we   = w && !wr_acc;
            if (rd_acc) m_out = m_q.pop_front();
            if (wr_acc) m_q.push_back(din);
        end
        @(posedge clk);
        #1;
        cyc++;
        check("out",       32'(out),       32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("count",     32'(count),     32'(m_q.size()));
        check("full",      32'(full),      32'(m_q.size() == 16));
        check("empty",     32'(empty),     32'(m_q.size() == 0));
        check("wr_err",    32'(wr_err),    32'(m_we));
        check("rd_err",    32'(rd_err),    32'(m_re));
    endtask

    initial begin
        rst = 1'b0; wr = 1'b0; rd = 1'b0; a = 16'h0000;

        // Reset held for two cycles
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        // Four writes, four back-to-back reads
        step(1'b1, 1'b1, 1'b0, 16'h1111);
        step(1'b1, 1'b1, 1'b0, 16'h2222);
        step(1'b1, 1'b1, 1'b0, 16'h3333);
        step(1'b1, 1'b1, 1'b0, 16'h4444);
        check("count_after_4", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 16'h0000);
        check("out_last_of_4", 32'(out), 32'h4444);

        // Fill to 16, overflow write, drain
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 16'(i));
        check("full_at_16", 32'(full), 32'd1);
        step(1'b1, 1'b1, 1'b0, 16'hBEEF);
        check("overflow_wr_err", 32'(wr_err), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 16'h0000);
        check("drained_empty", 32'(empty), 32'd1);

        // Underflow read, then simultaneous wr/rd on empty
        step(1'b1, 1'b0, 1'b1, 16'h0000);
        check("underflow_out_held", 32'(out), 32'h000F);
        step(1'b1, 1'b1, 1'b1, 16'hA5A5);
        check("empty_wrrd_count", 32'(count), 32'd1);
        step(1'b1, 1'b0, 1'b1, 16'h0000);
        check("a5a5_read", 32'(out), 32'hA5A5);

        // Fill, simultaneous wr/rd while full, drain with wrapped pointers
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 16'h7000 + 16'(i));
        step(1'b1, 1'b1, 1'b1, 16'h5A5A);
        check("full_wrrd_oldest", 32'(out), 32'h7000);
        check("full_wrrd_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 16'h0000);
        check("5a5a_last", 32'(out), 32'h5A5A);

        // Mid-operation reset discards data; next read rejected
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'hC000 + 16'(i));
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 16'h0000);
        check("post_reset_rd_err", 32'(rd_err), 32'd1);
        check("post_reset_out", 32'(out), 32'h0000);

        // Random traffic in phases biased towards filling, draining and balance
        for (int ph = 0; ph < 12; ph++) begin
            int wp;
            int rp;
            case (ph % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            for (int i = 0; i < 150; i++) begin
                logic r;
                logic w;
                logic d;
                r = ($urandom_range(0, 199) != 0);
                w = ($urandom_range(0, 99) < wp);
                d = ($urandom_range(0, 99) < rp);
                step(r, w, d, 16'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
        $finish;
    end

endmodule
